dmem_responder: RTL and testbench
=================================

# dmem_responder

Responder end of the memory bus for the single-cycle core's data and instruction ports. It holds word-organised RAM, accepts one request at a time from the initiator (the datapath side), inserts a programmable number of wait states, and returns read data or commits byte-masked write data with a one-cycle `ready` pulse. It lets the core run against a memory model with non-zero latency. It also flags misaligned and out-of-range accesses.

## Interface

Parameters:

- `DEPTH_WORDS`, 64: number of 32-bit words stored. Must be a power of two, at least 2.
- `WAIT_CYCLES`, 1: wait states between request acceptance and response, range 0..15.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0. Must be aligned to `DEPTH_WORDS*4`.

Ports:

- `clk`, input, 1: single clock. Everything is on the rising edge.
- `reset_n`, input, 1: synchronous, active-low reset.
- `req`, input, 1: request valid. The initiator holds it high with stable fields until `ready`.
- `we`, input, 1: 1 means write, 0 means read.
- `addr`, input, 32: byte address.
- `wdata`, input, 32: write data.
- `be`, input, 4: byte enables. `be[i]` covers `wdata[8i+7:8i]`.
- `rdata`, output, 32: read data. Valid only while `ready`=1 and `we` was 0.
- `ready`, output, 1: one-cycle completion pulse.
- `err`, output, 1: high together with `ready` when the access faulted.

## Operation

The FSM has three states: IDLE, WAIT and RESP.

- **IDLE**
  - On `req`=1, latch `addr`, `we`, `wdata` and `be`.
  - Go to WAIT if `WAIT_CYCLES`>0, otherwise go to RESP.
- **WAIT**
  - A 4-bit counter is loaded with `WAIT_CYCLES-1` on entry and decrements each cycle.
  - Go to RESP when the counter reaches 0.
  - Input changes are ignored because the latched copy is used.
- **RESP**
  - `ready`=1 for exactly this cycle, then go to IDLE.

Fault check, done on the latched request:

- Misaligned: `addr[1:0]`≠0.
- Out of range: `addr` < `BASE_ADDR` or `addr` ≥ `BASE_ADDR + DEPTH_WORDS*4`.

Any fault sets `err`=1 in RESP. A faulted write does not modify memory. A faulted read returns `rdata`=0.

Normal access:

- The word index is `(addr - BASE_ADDR) >> 2`, truncated to `$clog2(DEPTH_WORDS)` bits.
- **Write:** on the RESP clock edge, only the bytes with `be[i]`=1 are updated. `be`=0 makes a legal no-op write that still completes with `ready`.
- **Read:** `rdata` presents the full stored word during RESP. `be` is ignored for reads.
- Outside RESP, `rdata`=0, `ready`=0 and `err`=0.

Back-to-back requests:

- The responder returns to IDLE after RESP.
- If `req` is still high in IDLE, that is treated as a new request. The initiator must drop `req` in the cycle after `ready` unless it intends a new access.

Memory contents:

- Not reset. Simulation initialises them to 0.
- The RAM must be inferable as a single-port synchronous RAM: one access per cycle, with the read captured into a register at the WAIT→RESP or IDLE→RESP transition.

Reset (`reset_n`=0 at an edge):

- State goes to IDLE, the counter is cleared, `ready`=0, `err`=0 and `rdata`=0.
- A pending latched write is dropped and memory is not modified.
- Reset takes priority over every transition, including RESP.

## Timing

- Request accepted at edge N in IDLE: `ready` is high during cycle N+1+`WAIT_CYCLES`.
- The minimum request-to-request period is `WAIT_CYCLES`+2 cycles.
- The write commits on the edge that ends the RESP cycle. A read issued afterwards sees the new data.
- All outputs are registered. There is no combinational path from inputs to `ready`, `err` or `rdata`.
- With `WAIT_CYCLES`=0, `ready` rises in the cycle after acceptance, giving a latency of 1.

## Test plan

- **Reset:** hold `reset_n`=0 for 3 cycles with `req`=1. Expect `ready`=0, `err`=0 and `rdata`=0 throughout, and no access accepted until the first cycle after `reset_n`=1.
- **Write/read, WAIT_CYCLES=1:**
  - Write 32'hDEAD_BEEF to address 0x10 with `be`=4'hF. Expect `ready` exactly 2 cycles after acceptance and `err`=0.
  - Read 0x10. Expect `rdata`=32'hDEAD_BEEF with `ready`.
- **Byte mask:** after the previous scenario, write 32'h1122_3344 to 0x10 with `be`=4'b0101. A subsequent read returns 32'hDE22_BE44.
- **Faults:**
  - Read 0x13. Expect `ready`=1, `err`=1 and `rdata`=0.
  - Write to `BASE_ADDR + DEPTH_WORDS*4` (0x100 with defaults). Expect `err`=1, and a read of 0x0 remains unchanged.
- **Latency sweep:** run with `WAIT_CYCLES` set to 0, 3 and 15. Each `ready` lands at acceptance+1+`WAIT_CYCLES`. Hold `req` high continuously and check that requests repeat every `WAIT_CYCLES`+2 cycles.
- **Reset mid-op:**
  - With `WAIT_CYCLES`=3, accept a write of 32'hCAFE_0001 to 0x20, then assert `reset_n`=0 during WAIT. No `ready` is produced.
  - A read of 0x20 after reset returns the old value, 0.

Source files
------------

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Responder end of the core's memory bus. Holds a word-organised RAM,
// accepts one request at a time, inserts WAIT_CYCLES wait states, and then
// returns read data or commits a byte-masked write, signalled by a
// one-cycle ready pulse. Misaligned and out-of-range accesses complete
// normally but with err=1. They never touch memory and read back as 0.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words (power of two, >= 2)
//   WAIT_CYCLES : wait states between acceptance and response (0..15)
//   BASE_ADDR   : byte address of word 0 (aligned to DEPTH_WORDS*4)
//
// Ports
//   clk     : clock, rising edge
//   reset_n : synchronous active-low reset
//   req     : request valid, held with stable fields until ready
//   we      : 1 = write, 0 = read
//   addr    : byte address
//   wdata   : write data
//   be      : byte enables, be[i] covers wdata[8i+7:8i]
//   rdata   : read data, non-zero only in the response cycle of a good read
//   ready   : one-cycle completion pulse
//   err     : fault flag, only ever high together with ready
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    // The counter holds the number of wait cycles still to go after the
    // current one, so it is loaded with one less than the total.
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        accept;
    logic        to_resp;
    req_t        lat;

    // Request currently being served. In IDLE the request is still on the
    // bus, and it is needed directly when WAIT_CYCLES=0 takes IDLE straight
    // to RESP. In every other state the latched copy is used.
    logic        cur_we;
    logic [31:0] cur_addr;
    logic        fault;
    logic [AW-1:0] idx;

    logic [31:0] mem [DEPTH_WORDS];

    always_comb begin
        cur_we   = (state == ST_IDLE) ? we   : lat.we;
        cur_addr = (state == ST_IDLE) ? addr : lat.addr;
        // BASE_ADDR is aligned to the memory size, so an address is in range
        // exactly when its bits above the word index match the base. This
        // also avoids any overflow of BASE_ADDR + DEPTH_WORDS*4.
        fault    = (cur_addr[1:0] != 2'b00) ||
                   (cur_addr[31:AW+2] != BASE_ADDR[31:AW+2]);
        // The base has zeros in the index bits, so subtracting it leaves
        // them unchanged.
        idx      = cur_addr[AW+1:2];
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        to_resp   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = ST_RESP;
                        to_resp   = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = ST_RESP;
                    to_resp   = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counter and registered outputs. The outputs are loaded on the
    // edge that enters RESP and cleared on the edge that leaves it, so each
    // one is a single-cycle pulse that comes straight from a flop.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
            ready <= 1'b0;
            err   <= 1'b0;
            rdata <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ready <= to_resp;
            err   <= to_resp && fault;
            // This is the synchronous RAM read port. It is captured only on
            // entry to RESP, which is never the edge on which a write commits.
            rdata <= (to_resp && !cur_we && !fault) ? mem[idx] : 32'd0;
        end
    end

    // The latched request is ignored until it is next loaded, so it needs
    // no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat <= '{we: we, addr: addr, wdata: wdata, be: be};
        end
    end

    // The write commits on the edge that ends RESP. In RESP the index and
    // the fault flag both come from the latched request. A reset on that
    // edge drops the write.
    always_ff @(posedge clk) begin
        if (reset_n && state == ST_RESP && lat.we && !fault) begin
            for (int b = 0; b < 4; b++) begin
                if (lat.be[b]) begin
                    mem[idx][8*b +: 8] <= lat.wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: four instances with WAIT_CYCLES = 1, 0, 3, 15.
// A timeline model predicts ready/err/rdata for every instance on every
// cycle, and directed transactions pin the model with literal expectations.
module tb_dmem_responder;

    localparam int NI    = 4;
    localparam int DEPTH = 64;
    localparam longint BASE = 0;

    function automatic int wof(input int g);
        case (g)
            0: return 1;
            1: return 0;
            2: return 3;
            default: return 15;
        endcase
    endfunction

    logic        clk;
    logic        reset_n;
    logic        req   [NI];
    logic        we    [NI];
    logic [31:0] addr  [NI];
    logic [31:0] wdata [NI];
    logic [3:0]  be    [NI];
    logic [31:0] rdata [NI];
    logic        ready [NI];
    logic        err   [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_WORDS(DEPTH),
            .WAIT_CYCLES(wof(g)),
            .BASE_ADDR  (32'h0)
        ) u_dut (
            .clk    (clk),
            .reset_n(reset_n),
            .req    (req[g]),
            .we     (we[g]),
            .addr   (addr[g]),
            .wdata  (wdata[g]),
            .be     (be[g]),
            .rdata  (rdata[g]),
            .ready  (ready[g]),
            .err    (err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- model ----------------
    longint      cyc = 0;
    bit          pend    [NI];
    longint      resp_at [NI];
    longint      free_at [NI];
    bit          m_we    [NI];
    bit   [31:0] m_addr  [NI];
    bit   [31:0] m_wd    [NI];
    bit   [3:0]  m_be    [NI];
    bit   [31:0] mm      [NI][DEPTH];
    bit          x_rdy   [NI];
    bit          x_err   [NI];
    bit   [31:0] x_rd    [NI];
    int          pulses  [NI];

    function automatic bit bad(input bit [31:0] a);
        longint ua;
        ua = longint'(a);
        return (a[1:0] != 2'b00) || (ua < BASE) || (ua >= BASE + DEPTH * 4);
    endfunction

    function automatic int widx(input bit [31:0] a);
        return int'((longint'(a) - BASE) / 4) % DEPTH;
    endfunction

    // An access accepted on edge e is answered on edge e+W (outputs visible
    // until e+W+1) and commits on edge e+W+1. The next request can be
    // accepted no earlier than edge e+W+2.
    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < NI; i++) begin
            x_rdy[i] = 0;
            x_err[i] = 0;
            x_rd[i]  = 0;
            if (!reset_n) begin
                pend[i]    = 0;
                free_at[i] = cyc + 1;
            end else begin
                if (pend[i] && cyc == resp_at[i] + 1) begin
                    if (m_we[i] && !bad(m_addr[i])) begin
                        for (int b = 0; b < 4; b++)
                            if (m_be[i][b]) mm[i][widx(m_addr[i])][8*b +: 8] = m_wd[i][8*b +: 8];
                    end
                    pend[i] = 0;
                end
                if (!pend[i] && cyc >= free_at[i] && req[i] === 1'b1) begin
                    pend[i]    = 1;
                    m_we[i]    = we[i];
                    m_addr[i]  = addr[i];
                    m_wd[i]    = wdata[i];
                    m_be[i]    = be[i];
                    resp_at[i] = cyc + wof(i);
                    free_at[i] = cyc + wof(i) + 2;
                end
                if (pend[i] && cyc == resp_at[i]) begin
                    x_rdy[i] = 1;
                    x_err[i] = bad(m_addr[i]);
                    x_rd[i]  = (!m_we[i] && !bad(m_addr[i])) ? mm[i][widx(m_addr[i])] : 32'd0;
                end
            end
        end
    end

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if ({ready[i], err[i], rdata[i]} !== {x_rdy[i], x_err[i], x_rd[i]}) begin
                n_bad++;
                $display("FAIL cycle_cmp inst%0d @%0d: got rdy=%b err=%b rdata=%h, required rdy=%b err=%b rdata=%h",
                         i, cyc, ready[i], err[i], rdata[i], x_rdy[i], x_err[i], x_rd[i]);
            end
            if (ready[i] === 1'b1) pulses[i]++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // One access. lat counts negedges from the accepting edge to the one
    // where ready is seen, i.e. 1+WAIT_CYCLES. 0 means it timed out.
    task automatic txn(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d; be[i] = b;
        rd = 32'd0; er = 1'b0; lat = 0;
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (ready[i] === 1'b1) begin
                lat = n; rd = rdata[i]; er = err[i];
                break;
            end
        end
        req[i] = 1'b0;
    endtask

    // Holds req high for three reads of 0x0 and reports when ready arrives.
    task automatic burst(input int i, output int first, output int p1, output int p2);
        int t0, t1, t2, cnt;
        t0 = 0; t1 = 0; t2 = 0; cnt = 0;
        @(negedge clk);
        req[i] = 1'b1; we[i] = 1'b0; addr[i] = 32'h0; be[i] = 4'h0;
        @(posedge clk);
        for (int t = 1; t <= 100; t++) begin
            @(negedge clk);
            if (ready[i] === 1'b1) begin
                if (cnt == 0) t0 = t; else if (cnt == 1) t1 = t; else t2 = t;
                cnt++;
                if (cnt == 3) break;
            end
        end
        req[i] = 1'b0;
        first = t0; p1 = t1 - t0; p2 = t2 - t1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat, f, p1, p2, pb;

    initial begin
        reset_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            req[i] = 1'b1; we[i] = 1'b0; addr[i] = 32'h100; wdata[i] = 32'h0; be[i] = 4'hF;
            pulses[i] = 0;
        end
        // Reset held for three cycles with req high. The compare process
        // expects all-zero outputs throughout.
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) chk($sformatf("reset_pulses%0d", i), pulses[i], 0);
        reset_n = 1'b1;
        @(negedge clk);                 // first edge after release accepts
        for (int i = 0; i < NI; i++) req[i] = 1'b0;
        repeat (25) @(negedge clk);
        for (int i = 0; i < NI; i++) chk($sformatf("post_reset_pulses%0d", i), pulses[i], 1);

        // Clear the words that are read back later.
        for (int i = 0; i < NI; i++) begin
            txn(i, 1'b1, 32'h0,  32'h0, 4'hF, rd, er, lat);
            txn(i, 1'b1, 32'h20, 32'h0, 4'hF, rd, er, lat);
        end

        // WAIT_CYCLES=1 scenarios on instance 0.
        txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
        chk("wr_latency_w1", lat, 2);
        chk("wr_err", er, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        chk("rd_data", rd, 32'hDEAD_BEEF);
        chk("rd_latency_w1", lat, 2);
        txn(0, 1'b1, 32'h10, 32'h1122_3344, 4'b0101, rd, er, lat);
        txn(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
        chk("byte_mask", rd, 32'hDE22_BE44);
        txn(0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, rd, er, lat);
        chk("be0_ready", lat, 2);
        txn(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
        chk("be0_noop", rd, 32'hDE22_BE44);
        txn(0, 1'b0, 32'h13, 32'h0, 4'hF, rd, er, lat);
        chk("misalign_err", er, 1);
        chk("misalign_rdata", rd, 0);
        chk("misalign_lat", lat, 2);
        txn(0, 1'b1, 32'h100, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
        chk("oob_err", er, 1);
        txn(0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
        chk("oob_top_err", er, 1);
        txn(0, 1'b0, 32'h0, 32'h0, 4'hF, rd, er, lat);
        chk("oob_word0", rd, 0);
        chk("oob_word0_err", er, 0);
        txn(0, 1'b0, 32'hFC, 32'h0, 4'hF, rd, er, lat);
        chk("last_word_err", er, 0);

        // Latency sweep and back-to-back period.
        for (int i = 1; i < NI; i++) begin
            txn(i, 1'b1, 32'h8, 32'h0000_00A5 + i, 4'hF, rd, er, lat);
            chk($sformatf("latency_w%0d", wof(i)), lat, wof(i) + 1);
            txn(i, 1'b0, 32'h8, 32'h0, 4'hF, rd, er, lat);
            chk($sformatf("sweep_rd_w%0d", wof(i)), rd, 32'h0000_00A5 + i);
            burst(i, f, p1, p2);
            chk($sformatf("burst_first_w%0d", wof(i)), f, wof(i) + 1);
            chk($sformatf("burst_p1_w%0d", wof(i)), p1, wof(i) + 2);
            chk($sformatf("burst_p2_w%0d", wof(i)), p2, wof(i) + 2);
        end
        burst(0, f, p1, p2);
        chk("burst_p1_w1", p1, 3);

        // Reset in the middle of a WAIT_CYCLES=3 write.
        repeat (3) @(negedge clk);
        pb = pulses[2];
        req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h20; wdata[2] = 32'hCAFE_0001; be[2] = 4'hF;
        @(posedge clk);                 // accepted
        @(negedge clk);
        req[2] = 1'b0;
        reset_n = 1'b0;                 // next edge lands in WAIT
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("midop_no_ready", pulses[2] - pb, 0);
        txn(2, 1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
        chk("midop_old_value", rd, 0);
        chk("midop_rd_lat", lat, 4);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
